// File: rtl/rf_seq.sv
// ============================================================================
// Module   : rf_seq
// Brief    : Instruction-cycle sequencer for the 16x32 register file; drives
//            the fn_* strobes, the memory handshake and the debug hand-off.
//            Optional macro SINGLE_STEP_EN adds a one-instruction step input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_seq #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             mem_req,
  output logic             mem_fetch,
  input  logic             mem_ready,
  input  logic             dec_link,
  input  logic             dec_ra_chg,
  input  logic             dec_wb,
  input  logic             dec_mem,
  output logic             ir_we,
  output logic             fn_inc_pc,
  output logic             fn_link,
  output logic             fn_ra_change,
  output logic             fn_wb,
  output logic             dbg_mode,
  input  logic             dbg_req,
  input  logic             dbg_we,
  output logic             dbg_ack,
  output logic             halted,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [CNT_W-1:0] icnt
);

  localparam logic [2:0] S_HALT  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             ack_q, ack_d;
  logic             ackwe_q, ackwe_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic             retire;
  logic             live;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    ackwe_d = 1'b0;
    step_d  = step_q;
    retire  = 1'b0;
    case (state_q)
      S_HALT: begin
        // The ack cycle refuses a new request, so a held dbg_req acks every other cycle.
        if (dbg_req && !ack_q) begin
          ack_d   = 1'b1;
          ackwe_d = dbg_we;
        end else if (dbg_req) begin
          state_d = S_HALT;
        end else if (run) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
`ifdef SINGLE_STEP_EN
        end else if (step) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
`endif
        end
      end
      S_FETCH: begin
        if (mem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (dec_mem)     state_d = S_MEM;
        else if (dec_wb) state_d = S_WB;
        else             retire  = 1'b1;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (dec_wb) state_d = S_WB;
          else        retire  = 1'b1;
        end
      end
      S_WB: begin
        retire = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
    if (retire) begin
      state_d = (run && !step_q) ? S_FETCH : S_HALT;
      step_d  = 1'b0;
    end
  end

  assign icnt_d = retire ? icnt_q + CNT_W'(1) : icnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HALT;
      ack_q   <= 1'b0;
      ackwe_q <= 1'b0;
      step_q  <= 1'b0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ackwe_q <= ackwe_d;
      step_q  <= step_d;
      icnt_q  <= icnt_d;
    end
  end

  // Strobes are suppressed during a reset cycle so the register file is untouched.
  assign live         = !reset;
  assign mem_req      = live && (state_q == S_FETCH || state_q == S_MEM);
  assign mem_fetch    = live && (state_q == S_FETCH);
  assign ir_we        = live && (state_q == S_FETCH) && mem_ready;
  assign fn_inc_pc    = live && (state_q == S_FETCH) && mem_ready;
  assign fn_link      = live && (state_q == S_EXEC) && dec_link;
  assign fn_ra_change = live && (state_q == S_EXEC) && dec_ra_chg;
  assign fn_wb        = live && ((state_q == S_WB) ||
                                 (state_q == S_HALT && ack_q && ackwe_q));
  assign dbg_ack      = live && ack_q;
  assign halted       = (state_q == S_HALT);
  assign dbg_mode     = (state_q == S_HALT);
  assign icnt         = icnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_seq.sv
// ============================================================================
// Module   : tb_rf_seq
// Brief    : Self-checking bench for rf_seq (CNT_W=4) using a per-instruction
//            cycle-schedule reference model; covers SINGLE_STEP_EN if defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_seq;

  logic       clk;
  logic       reset, run, mem_ready;
  logic       dec_link, dec_ra_chg, dec_wb, dec_mem;
  logic       dbg_req, dbg_we;
  logic       mem_req, mem_fetch, ir_we, fn_inc_pc, fn_link, fn_ra_change, fn_wb;
  logic       dbg_mode, dbg_ack, halted;
  logic [3:0] icnt;
`ifdef SINGLE_STEP_EN
  logic       step;
`endif

  int         tests = 0;
  int         fails = 0;
  logic [3:0] m_icnt;
  bit         m_halted;
  logic [9:0] outs;

  rf_seq #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_fetch(mem_fetch), .mem_ready(mem_ready),
    .dec_link(dec_link), .dec_ra_chg(dec_ra_chg), .dec_wb(dec_wb), .dec_mem(dec_mem),
    .ir_we(ir_we), .fn_inc_pc(fn_inc_pc), .fn_link(fn_link),
    .fn_ra_change(fn_ra_change), .fn_wb(fn_wb), .dbg_mode(dbg_mode),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_ack(dbg_ack), .halted(halted),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .icnt(icnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign outs = {mem_req, mem_fetch, ir_we, fn_inc_pc, fn_link,
                 fn_ra_change, fn_wb, dbg_ack, halted, dbg_mode};

  function automatic logic [9:0] ev(bit req, bit fet, bit ir, bit inc, bit lnk,
                                    bit ra, bit wb, bit ack, bit hlt);
    return {req, fet, ir, inc, lnk, ra, wb, ack, hlt, hlt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already driven, sample at the falling edge, then advance.
  task automatic cyc(input logic [9:0] e, input string tag);
    @(negedge clk);
    chk(tag, {22'd0, outs}, {22'd0, e});
    @(posedge clk);
    #1;
  endtask

  localparam logic [9:0] E_HALT = 10'b00_0000_0011;

  task automatic halt_go();
    run = 1'b1; dbg_req = 1'b0;
    cyc(E_HALT, "halt_exit");
    m_halted = 1'b0;
  endtask

  // Expected schedule of one instruction: fetch wait, exec, optional mem wait, optional wb.
  task automatic do_instr(input bit lnk, input bit ra, input bit wb, input bit mem,
                          input int fw, input int mw, input bit next_run, input bit force_halt);
    for (int i = 0; i <= fw; i++) begin
      mem_ready = (i == fw);
      {dec_link, dec_ra_chg, dec_wb, dec_mem} = 4'($urandom);
      run = 1'($urandom); dbg_req = 1'($urandom); dbg_we = 1'($urandom);
`ifdef SINGLE_STEP_EN
      step = 1'($urandom);
`endif
      cyc(ev(1, 1, i == fw, i == fw, 0, 0, 0, 0, 0), "fetch");
    end
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    dec_link = lnk; dec_ra_chg = ra; dec_wb = wb; dec_mem = mem;
    mem_ready = 1'($urandom);
    run = (!mem && !wb) ? next_run : 1'($urandom);
    cyc(ev(0, 0, 0, 0, lnk, ra, 0, 0, 0), "exec");
    if (mem) begin
      for (int j = 0; j <= mw; j++) begin
        mem_ready = (j == mw);
        run = (j == mw && !wb) ? next_run : 1'($urandom);
        cyc(ev(1, 0, 0, 0, 0, 0, 0, 0, 0), "mem");
      end
    end
    if (wb) begin
      mem_ready = 1'($urandom);
      run = next_run;
      cyc(ev(0, 0, 0, 0, 0, 0, 1, 0, 0), "wb");
    end
    m_icnt++;
    chk("icnt", {28'd0, icnt}, {28'd0, m_icnt});
    m_halted = force_halt || !next_run;
    run = next_run; dbg_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    dec_link = 1'b0; dec_ra_chg = 1'b0; dec_wb = 1'b0; dec_mem = 1'b0;
`ifdef SINGLE_STEP_EN
    step = 1'b0;
`endif
    m_icnt = 4'd0; m_halted = 1'b1;
    @(posedge clk); #1;
    cyc(E_HALT, "reset");
    chk("reset_icnt", {28'd0, icnt}, 32'd0);
    reset = 1'b0;

    // Zero-wait straight-line code: one retire every two cycles.
    halt_go();
    for (int k = 0; k < 5; k++) do_instr(0, 0, 0, 0, 0, 0, 1, 0);
    chk("icnt_after_10", {28'd0, icnt}, 32'd5);

    // Call with data access and write-back, memory three cycles late.
    do_instr(1, 0, 1, 1, 0, 3, 1, 0);
    // run drops during the MEM wait: retire then halt.
    do_instr(0, 1, 0, 1, 1, 2, 0, 0);
    run = 1'b0;
    cyc(E_HALT, "halt_after_drop");
    cyc(E_HALT, "halt_idle");

    // Held debug read: ack on alternate cycles, no write strobe.
    dbg_req = 1'b1; dbg_we = 1'b0;
    cyc(E_HALT, "dbg_hold_1");
    cyc(E_HALT | ev(0, 0, 0, 0, 0, 0, 0, 1, 0), "dbg_hold_2");
    cyc(E_HALT, "dbg_hold_3");
    cyc(E_HALT | ev(0, 0, 0, 0, 0, 0, 0, 1, 0), "dbg_hold_4");
    dbg_req = 1'b0;
    cyc(E_HALT, "dbg_hold_5");

    // Debug write together with run: debug first, then fetch.
    dbg_req = 1'b1; dbg_we = 1'b1; run = 1'b1;
    cyc(E_HALT, "dbg_wr_req");
    dbg_req = 1'b0; dbg_we = 1'b0;
    cyc(E_HALT | ev(0, 0, 0, 0, 0, 0, 1, 1, 0), "dbg_wr_ack");
    m_halted = 1'b0;
    do_instr(0, 0, 1, 0, 1, 0, 1, 0);

    // Randomized instruction mix; icnt wraps past 15 along the way.
    for (int k = 0; k < 40; k++) begin
      if (m_halted) halt_go();
      do_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               ($urandom % 4) != 0, 0);
    end

    // Reset while a fetch is outstanding.
    if (m_halted) halt_go();
    mem_ready = 1'b0; run = 1'b1;
    cyc(ev(1, 1, 0, 0, 0, 0, 0, 0, 0), "fetch_wait");
    reset = 1'b1; mem_ready = 1'b1;
    cyc(10'd0, "rst_in_fetch");
    reset = 1'b0; run = 1'b0; mem_ready = 1'b0;
    cyc(E_HALT, "halt_after_rst");
    m_icnt = 4'd0; m_halted = 1'b1;
    chk("icnt_after_rst", {28'd0, icnt}, 32'd0);

`ifdef SINGLE_STEP_EN
    step = 1'b1; run = 1'b0;
    cyc(E_HALT, "step_pulse");
    step = 1'b0;
    do_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'($urandom), 1);
    run = 1'b0;
    cyc(E_HALT, "step_halt");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
